// File: rtl/reg_pipe.sv
// reg_pipe: stallable, flushable WIDTH x DEPTH delay line with per-stage
// valid bits, live occupancy count and a registered dropped-input flag.
module reg_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       stall,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       in_drop
);

  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [OW-1:0]    occ;
  logic [OW-1:0]    occ_nxt;
  logic             drop;

  // Net change is at most +/-1 and the true count stays in 0..DEPTH,
  // so modular arithmetic at OW bits is exact.
  always_comb begin
    occ_nxt = occ + OW'(in_valid) - OW'(v[DEPTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
      v    <= '0;
      occ  <= '0;
      drop <= 1'b0;
    end else if (flush) begin
      v    <= '0;
      occ  <= '0;
      drop <= in_valid;
    end else if (stall) begin
      drop <= in_valid;
    end else begin
      d[0] <= in_data;
      v[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        d[i] <= d[i-1];
        v[i] <= v[i-1];
      end
      occ  <= occ_nxt;
      drop <= 1'b0;
    end
  end

  assign out_data  = d[DEPTH-1];
  assign out_valid = v[DEPTH-1];
  assign occupancy = occ;
  assign in_drop   = drop;

endmodule

// File: doc/reg_pipe.md
# reg_pipe

Parametrised multi-stage register pipeline: the successor to the single-bit posedge D flip-flop. It is generalised to WIDTH bits and DEPTH stages and adds a per-stage valid bit, a global stall, a synchronous flush, a live occupancy count and a dropped-input indicator. It sits between producer and consumer blocks that need a fixed, stallable delay line with data qualification.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VAL, 0, value loaded into every data stage on reset (WIDTH bits)
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  data presented to stage 0
- in_valid  input  1  in_data is valid this cycle
- stall  input  1  freeze all stages
- flush  input  1  synchronously invalidate all stages
- out_data  output  WIDTH  data of stage DEPTH-1
- out_valid  output  1  valid bit of stage DEPTH-1
- occupancy  output  $clog2(DEPTH+1)  number of stages holding valid data
- in_drop  output  1  registered pulse: a valid input was discarded on the previous edge

## Operation
- State: data stages d[0..DEPTH-1], valid bits v[0..DEPTH-1], occupancy counter, in_drop register.
- Reset (rst_n low, asynchronous, takes effect immediately, no clock needed):
  - every d[i] = RESET_VAL, every v[i] = 0
  - occupancy = 0, in_drop = 0
  - out_data = RESET_VAL, out_valid = 0
- Priority at each rising edge: reset > flush > stall > advance.
- Flush:
  - all v[i] <= 0, occupancy <= 0; d[i] keep their values
  - in_drop <= in_valid; the input is discarded
- Stall (flush low):
  - all d[i], v[i] and occupancy hold
  - in_drop <= in_valid
- Advance (flush low, stall low):
  - d[0] <= in_data, v[0] <= in_valid
  - d[i] <= d[i-1] and v[i] <= v[i-1] for i = 1..DEPTH-1
  - occupancy <= occupancy + in_valid - v[DEPTH-1]
  - in_drop <= 0
- Bubbles (in_valid = 0) are not collapsed; they travel through the pipe like data.
- d[0] loads in_data even when in_valid = 0; the value is don't-care, but it is deterministic.
- out_data = d[DEPTH-1] and out_valid = v[DEPTH-1], driven directly from the registers with no combinational path from the inputs.
- occupancy always equals the popcount of v[]. It never exceeds DEPTH and never underflows.
- DEPTH = 1 degenerates to a single enable/clear register with valid.

## Timing
- Latency: a valid input sampled at edge k appears on out_valid/out_data after edge k+DEPTH-1, so it is visible in the cycle following that edge (DEPTH edges total, counting edge k), when no stall or flush occurs. Each stalled edge in between adds one cycle.
- Throughput: one item per cycle while stall = 0.
- in_drop asserts for exactly one cycle after each edge that discarded a valid input. Consecutive dropping edges give a continuous high.
- Flush and stall both high: flush wins, and the pipe is empty after the edge.
- Reset released mid-operation: the first edge with rst_n high behaves as a normal edge from the all-empty state.
- Reset asserted mid-operation: all outputs go to their reset values immediately; any in-flight data is lost and does not raise in_drop.

## Test plan
- Reset, WIDTH=8, DEPTH=4: hold rst_n = 0 with in_valid = 1 and in_data = 0xFF -> out_valid = 0, out_data = 0x00, occupancy = 0, in_drop = 0, with no clock edge needed.
- Stream: drive 0x11, 0x22, 0x33 on consecutive edges, then in_valid = 0 -> 0x11 is seen on out_data with out_valid = 1 in the cycle after the 4th edge; 0x22 and 0x33 follow on the next cycles; occupancy sequence after each edge is 1, 2, 3, 3, 2, 1, 0.
- Stall: load 0xA5, then stall for 3 edges while in_valid = 1 -> 0xA5 reaches the output 3 cycles later than unstalled; occupancy stays at 1 during the stall; in_drop is high for the 3 cycles following the stalled edges.
- Flush: fill all 4 stages (occupancy = 4), then flush = stall = 1 with in_valid = 1 for one edge -> occupancy = 0, out_valid = 0, in_drop = 1 for one cycle; the next valid input emerges after 4 edges.
- Bubbles: send the pattern valid/invalid/valid (0x01, x, 0x03) -> out_valid follows 1, 0, 1 starting 4 edges later; occupancy peaks at 2.
- Mid-stream reset: pulse rst_n low between edges with occupancy = 3 -> outputs clear immediately; after release, a new input 0x5A emerges after 4 edges with nothing stale ahead of it.
